// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo_guard flow-control front end.
package fifo_pkg;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_LVL_W-1:0] fifo_lvl_t;
endpackage

// File: rtl/fifo_guard_stats.sv
// Occupancy statistics: high-water mark and saturating push/pop counters.
module fifo_guard_stats
  import fifo_pkg::*;
#(
  parameter int LVL_W = FIFO_LVL_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] hwm,
  output logic [15:0]      push_cnt,
  output logic [15:0]      pop_cnt
);
  logic [LVL_W-1:0] hwm_q, hwm_d;
  logic [15:0]      push_cnt_q, push_cnt_d;
  logic [15:0]      pop_cnt_q, pop_cnt_d;

  always_comb begin
    hwm_d      = hwm_q;
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    if (level > hwm_q) hwm_d = level;
    if (push && push_cnt_q != 16'hFFFF)
      push_cnt_d = push_cnt_q + 16'd1;
    if (pop && pop_cnt_q != 16'hFFFF)
      pop_cnt_d = pop_cnt_q + 16'd1;
    if (!reset_n) begin
      hwm_d      = '0;
      push_cnt_d = '0;
      pop_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hwm_q      <= '0;
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      hwm_q      <= hwm_d;
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  assign hwm      = hwm_q;
  assign push_cnt = push_cnt_q;
  assign pop_cnt  = pop_cnt_q;
endmodule

// File: rtl/fifo_guard.sv
// Valid/ready front end for the FIFO storage block with shadow occupancy.
// Define FIFO_GUARD_STATS_EN to add hwm/push_cnt/pop_cnt statistics ports.
module fifo_guard
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int LVL_W    = $clog2(DEPTH + 1),
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             FIFO_clr_n,
  input  logic             FIFO_reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic [LVL_W-1:0] level,
`ifdef FIFO_GUARD_STATS_EN
  output logic [LVL_W-1:0] hwm,
  output logic [15:0]      push_cnt,
  output logic [15:0]      pop_cnt,
`endif
  output logic             empty,
  output logic             full,
  output logic             almost_full
);
  logic [LVL_W-1:0] level_q, level_d;
  logic             rst_act;

  assign rst_act = !FIFO_clr_n || !FIFO_reset_n;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_W'(DEPTH));
  assign almost_full = (level_q >= LVL_W'(AF_LEVEL));

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready && !rst_act;
  assign pop  = out_valid && out_ready && !rst_act;

  assign data_in  = in_data;
  assign out_data = fifo_rd_data;
  assign level    = level_q;

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      push && !pop: level_d = level_q + LVL_W'(1);
      pop && !push: level_d = level_q - LVL_W'(1);
      default:      level_d = level_q;
    endcase
    if (!FIFO_reset_n) level_d = '0;
  end

  always_ff @(posedge clk or negedge FIFO_clr_n) begin
    if (!FIFO_clr_n) level_q <= '0;
    else             level_q <= level_d;
  end

`ifdef FIFO_GUARD_STATS_EN
  fifo_guard_stats #(
    .LVL_W(LVL_W)
  ) u_stats (
    .clk      (clk),
    .clr_n    (FIFO_clr_n),
    .reset_n  (FIFO_reset_n),
    .push     (push),
    .pop      (pop),
    .level    (level_q),
    .hwm      (hwm),
    .push_cnt (push_cnt),
    .pop_cnt  (pop_cnt)
  );
`endif
endmodule

// File: tb/tb_fifo_guard.sv
// Directed bench for fifo_guard with a storage model and data scoreboard.
module tb_fifo_guard;
  logic       clk = 1'b0;
  logic       FIFO_clr_n;
  logic       FIFO_reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] fifo_rd_data;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       almost_full;
`ifdef FIFO_GUARD_STATS_EN
  logic [4:0]  hwm;
  logic [15:0] push_cnt;
  logic [15:0] pop_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  int         mlvl;
  int         mhwm;
  int         mpush;
  int         mpop;
  logic [7:0] exp_q[$];

  logic [7:0] mem[16];
  logic [3:0] wp, rp;

  always #5 clk = ~clk;

  fifo_guard dut (
    .clk          (clk),
    .FIFO_clr_n   (FIFO_clr_n),
    .FIFO_reset_n (FIFO_reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .fifo_rd_data (fifo_rd_data),
    .level        (level),
`ifdef FIFO_GUARD_STATS_EN
    .hwm          (hwm),
    .push_cnt     (push_cnt),
    .pop_cnt      (pop_cnt),
`endif
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full)
  );

  // Stand-in for the attached FIFO storage block
  always @(posedge clk or negedge FIFO_clr_n) begin
    if (!FIFO_clr_n) begin
      wp <= '0;
      rp <= '0;
    end else if (!FIFO_reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp] <= data_in;
        wp      <= wp + 4'd1;
      end
      if (pop) rp <= rp + 4'd1;
    end
  end
  assign fifo_rd_data = mem[rp];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".level"}, 32'(level), 32'(mlvl));
    check({tag, ".empty"}, 32'(empty), 32'(mlvl == 0));
    check({tag, ".full"}, 32'(full), 32'(mlvl == 16));
    check({tag, ".af"}, 32'(almost_full), 32'(mlvl >= 12));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(mlvl != 16));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mlvl != 0));
  endtask

  task automatic model_clear();
    mlvl  = 0;
    mhwm  = 0;
    mpush = 0;
    mpop  = 0;
    exp_q.delete();
  endtask

  task automatic step(input string tag, input logic iv, input logic [7:0] d,
                      input logic ordy, input logic srst);
    logic ep, epop;
    @(negedge clk);
    in_valid     = iv;
    in_data      = d;
    out_ready    = ordy;
    FIFO_reset_n = !srst;
    #1;
    ep   = iv && (mlvl != 16) && !srst;
    epop = ordy && (mlvl != 0) && !srst;
    check({tag, ".push"}, 32'(push), 32'(ep));
    check({tag, ".pop"}, 32'(pop), 32'(epop));
    check({tag, ".data_in"}, 32'(data_in), 32'(d));
    if (epop && exp_q.size() > 0)
      check({tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
    @(posedge clk);
    #1;
    if (srst) begin
      model_clear();
    end else begin
      if (mlvl > mhwm) mhwm = mlvl;
      if (ep) begin
        exp_q.push_back(d);
        mpush++;
        mlvl++;
      end
      if (epop) begin
        void'(exp_q.pop_front());
        mpop++;
        mlvl--;
      end
    end
    check_flags(tag);
  endtask

  initial begin
    in_valid     = 1'b1;
    in_data      = 8'h00;
    out_ready    = 1'b1;
    FIFO_reset_n = 1'b1;
    FIFO_clr_n   = 1'b0;
    model_clear();
    #3;
    check("rst.push", 32'(push), 32'd0);
    check("rst.pop", 32'(pop), 32'd0);
    check_flags("rst");
    #20;
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    FIFO_clr_n = 1'b1;
    #1;
    check_flags("rel");
    check("rel.push", 32'(push), 32'd0);
    check("rel.pop", 32'(pop), 32'd0);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("fill17", 1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drain17", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step("to5", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step("sim5", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("to0", 1'b0, 8'h00, 1'b1, 1'b0);
    step("sim0", 1'b1, 8'h66, 1'b1, 1'b0);
    step("sim0.b", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step("to16", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step("sim16", 1'b1, 8'h99, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) step("to9", 1'b0, 8'h00, 1'b1, 1'b0);
    check("lvl9", 32'(level), 32'd9);
    step("srst", 1'b1, 8'hBB, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2;
    FIFO_clr_n = 1'b0;
    #1;
    model_clear();
    check_flags("clr");
    check("clr.push", 32'(push), 32'd0);
    check("clr.pop", 32'(pop), 32'd0);
    #1;
    FIFO_clr_n = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    step("postclr", 1'b0, 8'h00, 1'b0, 1'b0);
    step("postclr.w", 1'b1, 8'hD1, 1'b0, 1'b0);
    step("postclr.r", 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef FIFO_GUARD_STATS_EN
    step("st.rst", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("st.w", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("st.r", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("st.w2", 1'b1, 8'(i), 1'b0, 1'b0);
    step("st.idle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("st.hwm", 32'(hwm), 32'(mhwm));
    check("st.push_cnt", 32'(push_cnt), 32'(mpush));
    check("st.pop_cnt", 32'(pop_cnt), 32'(mpop));
    check("st.push13", 32'(push_cnt), 32'd13);
    check("st.pop4", 32'(pop_cnt), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
